// File: rtl/sgb_pkg.sv
// Shared SGB definitions: MLT_REQ mode encodings, P14/P15 select codes and
// joypad button bit positions within a player's 8-bit button byte.
package sgb_pkg;

  typedef enum logic [1:0] {
    MLT_1P = 2'd0,
    MLT_2P = 2'd1,
    MLT_4P = 2'd3
  } mlt_mode_t;

  localparam logic [1:0] P54_DIR  = 2'b10;
  localparam logic [1:0] P54_BTN  = 2'b01;
  localparam logic [1:0] P54_IDLE = 2'b11;
  localparam logic [1:0] P54_RST  = 2'b00;

  localparam int BTN_RT  = 0;
  localparam int BTN_LF  = 1;
  localparam int BTN_UP  = 2;
  localparam int BTN_DN  = 3;
  localparam int BTN_A   = 4;
  localparam int BTN_B   = 5;
  localparam int BTN_SEL = 6;
  localparam int BTN_ST  = 7;

  // Requested mode limited to the players actually wired; code 2 reads as 1P.
  function automatic mlt_mode_t clamp_mode(input logic [1:0] req, input int num_players);
    mlt_mode_t m;
    m = MLT_1P;
    if (req == 2'd3 && num_players >= 4)      m = MLT_4P;
    else if (req[0] && num_players >= 2)      m = MLT_2P;
    return m;
  endfunction

endpackage

// File: rtl/sgb_joy_sel.sv
// Combinational nibble select for the core's joypad port, active low.
// Idle reads return the player ID in multiplayer modes.
module sgb_joy_sel
  import sgb_pkg::*;
(
  input  logic [7:0] btn,
  input  logic [1:0] idx,
  input  logic [1:0] p54,
  input  logic       multi,
  output logic [3:0] nibble
);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nibble = 4'hF;
    unique case (p54)
      P54_DIR:  nibble = ~{btn[BTN_DN], btn[BTN_UP], btn[BTN_LF], btn[BTN_RT]};
      P54_BTN:  nibble = ~{btn[BTN_ST], btn[BTN_SEL], btn[BTN_B], btn[BTN_A]};
      P54_IDLE: nibble = multi ? (4'hF - {2'b00, idx}) : 4'hF;
      P54_RST:  nibble = 4'hF;
    endcase
  end

endmodule

// File: rtl/sgb_joy_mux.sv
// SGB multi-player joypad multiplexer: samples per-player buttons, drives the
// selected player's nibble to the core and advances the player on each button read.
module sgb_joy_mux
  import sgb_pkg::*;
#(
  parameter int NUM_PLAYERS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  input  logic [1:0]               mlt_req,
  input  logic                     mlt_wr,
  input  logic [1:0]               joy_p54,
  input  logic [8*NUM_PLAYERS-1:0] joy_btn,
  output logic [3:0]               joy_din,
  output logic [1:0]               player_idx,
  output logic                     pkt_pulse
);

  logic [8*NUM_PLAYERS-1:0] btn_q;
  logic [1:0]               p54_q;
  logic [1:0]               p54_d;
  mlt_mode_t                mode;
  logic [7:0]               player_btn;
  logic [3:0]               nibble;
  logic [1:0]               last_idx;
  logic                     multi;
  logic                     advance;
  logic                     pkt_edge;

  always_comb begin
    player_btn = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      if (player_idx == 2'(p)) player_btn = btn_q[8*p +: 8];
  end

  assign multi    = (mode != MLT_1P);
  assign last_idx = (mode == MLT_4P) ? 2'd3 : 2'd1;
  // A button read ends when P15 is released back to idle.
  assign advance  = multi && (p54_d == P54_BTN) && (p54_q == P54_IDLE);
  assign pkt_edge = (p54_d != P54_RST) && (p54_q == P54_RST);

  sgb_joy_sel u_sel (
    .btn    (player_btn),
    .idx    (player_idx),
    .p54    (p54_q),
    .multi  (multi),
    .nibble (nibble)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q      <= '0;
      p54_q      <= '0;
      p54_d      <= '0;
      mode       <= MLT_1P;
      player_idx <= '0;
      joy_din    <= 4'hF;
      pkt_pulse  <= 1'b0;
    end else begin
      p54_q     <= joy_p54;
      p54_d     <= p54_q;
      joy_din   <= nibble;
      pkt_pulse <= pkt_edge;
      if (clk_en) btn_q <= joy_btn;
      // A mode write overrides a coincident advance.
      if (mlt_wr) begin
        mode       <= clamp_mode(mlt_req, NUM_PLAYERS);
        player_idx <= '0;
      end else if (advance) begin
        player_idx <= (player_idx == last_idx) ? 2'd0 : player_idx + 2'd1;
      end
    end
  end

endmodule
